// File: rtl/imc_array_sequencer.sv
// Phase sequencer for one SRAM in-memory-compute macro: bitcell write,
// single-row sense-amp read and ternary multi-row MAC, with programmable
// phase durations and a valid/ready response port.
module imc_array_sequencer #(
    parameter int MEM_ROW        = 16,
    parameter int MEM_COL        = 16,
    parameter int SRAM_OUT_WIDTH = 16,
    parameter int IMC_OUT_WIDTH  = 16,
    parameter int ROW_ADDR_W     = 5,
    parameter int TW             = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [ROW_ADDR_W-1:0]     cmd_row,
    input  logic [MEM_COL-1:0]        cmd_data,
    input  logic [MEM_ROW-1:0]        cmd_vec_p,
    input  logic [MEM_ROW-1:0]        cmd_vec_n,
    input  logic [TW-1:0]             t_pre,
    input  logic [TW-1:0]             t_wl,
    input  logic [TW-1:0]             t_sa,
    output logic                      PRE_SRAM,
    output logic                      WE,
    output logic                      PRE_VLSA,
    output logic                      PRE_CLSA,
    output logic                      PRE_A,
    output logic                      SAEN,
    output logic                      EN_VCLP,
    output logic [MEM_ROW-1:0]        WWL,
    output logic [MEM_ROW-1:0]        RWL,
    output logic [MEM_ROW-1:0]        RWLB,
    output logic [MEM_COL-1:0]        SRAM_Din,
    input  logic [SRAM_OUT_WIDTH-1:0] SA_out,
    input  logic [IMC_OUT_WIDTH-1:0]  IMC_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IMC_OUT_WIDTH-1:0]  rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_MAC   = 2'b11;
    localparam logic [ROW_ADDR_W-1:0] ROW_LIMIT = ROW_ADDR_W'(MEM_ROW);

    typedef enum logic [3:0] {
        IDLE, W_PRE, W_WL, W_REC,
        R_PRE, R_WL, R_SA, R_CAP,
        M_PRE, M_WL, M_SA, M_CAP,
        ERR, RESP
    } state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         cnt, cnt_nxt;
    logic [ROW_ADDR_W-1:0] row_q;
    logic [MEM_COL-1:0]    data_q;
    logic [MEM_ROW-1:0]    vec_p_q, vec_n_q;
    logic [TW-1:0]         tw_q, ts_q;
    logic [MEM_ROW-1:0]    row_hot;
    logic [MEM_ROW-1:0]    mac_pos, mac_neg;
    logic                  row_ok;

    // A phase of t cycles ends when the down-counter reaches 0; t=0 acts as 1.
    function automatic logic [TW-1:0] last_cnt(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    assign cmd_ready = (state == IDLE) && reset_n;
    assign busy      = (state != IDLE);
    assign row_ok    = (cmd_row < ROW_LIMIT);
    assign row_hot   = {{(MEM_ROW-1){1'b0}}, 1'b1} << row_q;
    // Conflicting ternary bits (both +1 and -1) leave the row undriven.
    assign mac_pos   = vec_p_q & ~vec_n_q;
    assign mac_neg   = vec_n_q & ~vec_p_q;

    // State and phase counter; reset aborts any sequence in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Command capture on accept so later input changes cannot disturb a sequence.
    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            row_q   <= cmd_row;
            data_q  <= cmd_data;
            vec_p_q <= cmd_vec_p;
            vec_n_q <= cmd_vec_n;
            tw_q    <= t_wl;
            ts_q    <= t_sa;
        end
    end

    // Response register: loaded in the capture/error states, held through RESP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ERR: begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
                R_CAP: begin
                    rsp_data <= IMC_OUT_WIDTH'(SA_out);
                    rsp_err  <= 1'b0;
                end
                M_CAP: begin
                    rsp_data <= IMC_out;
                    rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state, counter reload on phase entry, and macro pin decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
        PRE_SRAM  = 1'b0;
        WE        = 1'b0;
        PRE_VLSA  = 1'b0;
        PRE_CLSA  = 1'b0;
        PRE_A     = 1'b0;
        SAEN      = 1'b0;
        EN_VCLP   = 1'b0;
        WWL       = '0;
        RWL       = '0;
        RWLB      = '0;
        SRAM_Din  = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            state_nxt = row_ok ? W_PRE : ERR;
                            cnt_nxt   = last_cnt(t_pre);
                        end
                        OP_READ: begin
                            state_nxt = row_ok ? R_PRE : ERR;
                            cnt_nxt   = last_cnt(t_pre);
                        end
                        OP_MAC: begin
                            state_nxt = M_PRE;
                            cnt_nxt   = last_cnt(t_pre);
                        end
                        default: ;
                    endcase
                end
            end
            W_PRE: begin
                PRE_SRAM = 1'b1;
                if (cnt == '0) begin
                    state_nxt = W_WL;
                    cnt_nxt   = last_cnt(tw_q);
                end
            end
            W_WL: begin
                WWL      = row_hot;
                WE       = 1'b1;
                SRAM_Din = data_q;
                if (cnt == '0) state_nxt = W_REC;
            end
            W_REC: state_nxt = IDLE;
            R_PRE: begin
                PRE_SRAM = 1'b1;
                PRE_VLSA = 1'b1;
                if (cnt == '0) begin
                    state_nxt = R_WL;
                    cnt_nxt   = last_cnt(tw_q);
                end
            end
            R_WL: begin
                RWL = row_hot;
                if (cnt == '0) begin
                    state_nxt = R_SA;
                    cnt_nxt   = last_cnt(ts_q);
                end
            end
            R_SA: begin
                RWL  = row_hot;
                SAEN = 1'b1;
                if (cnt == '0) state_nxt = R_CAP;
            end
            R_CAP: state_nxt = RESP;
            M_PRE: begin
                PRE_SRAM = 1'b1;
                PRE_CLSA = 1'b1;
                PRE_A    = 1'b1;
                EN_VCLP  = 1'b1;
                if (cnt == '0) begin
                    state_nxt = M_WL;
                    cnt_nxt   = last_cnt(tw_q);
                end
            end
            M_WL: begin
                RWL     = mac_pos;
                RWLB    = mac_neg;
                EN_VCLP = 1'b1;
                if (cnt == '0) begin
                    state_nxt = M_SA;
                    cnt_nxt   = last_cnt(ts_q);
                end
            end
            M_SA: begin
                RWL     = mac_pos;
                RWLB    = mac_neg;
                EN_VCLP = 1'b1;
                SAEN    = 1'b1;
                if (cnt == '0) state_nxt = M_CAP;
            end
            M_CAP: state_nxt = RESP;
            ERR:   state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/imc_array_sequencer.md
Name: imc_array_sequencer

Overview:
Parametrised phase sequencer that drives one SRAM in-memory-compute macro: bitcell write, single-row sense-amp read, and ternary multi-row MAC.
- Generalises the fixed-size wrapper control with programmable per-phase durations, a ternary input vector on RWL/RWLB, out-of-range error reporting, and a valid/ready result port with backpressure.
- Sits between the wishbone-side controller (command/response) and the analog macro (control pins in, SA/IMC results back).

Parameters:
MEM_ROW, 16, number of array rows (WWL/RWL/RWLB width)
MEM_COL, 16, write data width (Din)
SRAM_OUT_WIDTH, 16, SA_out width; must be <= IMC_OUT_WIDTH
IMC_OUT_WIDTH, 16, IMC_out width and rsp_data width
ROW_ADDR_W, 5, row address width; must exceed clog2(MEM_ROW) so out-of-range rows are encodable
TW, 4, width of each timing field

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 MAC
cmd_row  in  ROW_ADDR_W  row for WRITE/READ
cmd_data  in  MEM_COL  WRITE data
cmd_vec_p  in  MEM_ROW  MAC +1 rows (RWL)
cmd_vec_n  in  MEM_ROW  MAC -1 rows (RWLB)
t_pre, t_wl, t_sa  in  TW each  phase durations in cycles
PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, EN_VCLP  out  1 each  macro controls
WWL, RWL, RWLB  out  MEM_ROW each  wordlines
SRAM_Din  out  MEM_COL  write data to macro
SA_out  in  SRAM_OUT_WIDTH  sense-amp result
IMC_out  in  IMC_OUT_WIDTH  CLSA/MAC result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  IMC_OUT_WIDTH  result
rsp_err  out  1  out-of-range command
busy  out  1  high when not IDLE

Behaviour:
- Reset:
  - State goes to IDLE at the first clk edge with reset_n=0.
  - All macro controls, wordlines, SRAM_Din, rsp_valid, rsp_data, rsp_err and busy are 0. cmd_ready is also 0 while reset_n=0.
  - Reset mid-operation aborts the sequence, drops any pending response and clears all wordlines on that same edge.
- cmd_ready = (state==IDLE) & reset_n. On accept, the sequencer latches op, row, data, vectors and t_pre/t_wl/t_sa. Later input changes have no effect.
- Phase length = max(t,1) cycles; a field value of 0 behaves as 1. Written Tp, Tw, Ts below.
- NOP: accepted and dropped. No response; stays IDLE.
- Range check (WRITE/READ only): cmd_row >= MEM_ROW gives no macro activity and goes to RESP with rsp_err=1, rsp_data=0.
- WRITE sequence: W_PRE (PRE_SRAM=1, Tp) -> W_WL (WWL[row]=1, WE=1, SRAM_Din=data, Tw) -> W_REC (all controls 0, 1 cycle) -> IDLE.
  - No response.
  - cmd_ready returns Tp+Tw+1 cycles after accept.
- READ sequence: R_PRE (PRE_SRAM=1, PRE_VLSA=1, Tp) -> R_WL (RWL[row]=1, Tw) -> R_SA (RWL[row]=1, SAEN=1, Ts) -> R_CAP (controls 0; rsp_data <= zero-extended SA_out sampled this edge) -> RESP.
- MAC sequence: M_PRE (PRE_SRAM=1, PRE_CLSA=1, PRE_A=1, EN_VCLP=1, Tp) -> M_WL (RWL=vec_p&~vec_n, RWLB=vec_n&~vec_p, EN_VCLP=1, Tw) -> M_SA (same, plus SAEN=1, Ts) -> M_CAP (rsp_data <= IMC_out) -> RESP.
  - Rows with both vector bits set are driven as 0 on both lines.
  - cmd_row is ignored.
- RESP: rsp_valid=1 and rsp_data/rsp_err are held stable until rsp_ready. The handshake edge returns to IDLE with rsp_valid=0.
- Latency, READ/MAC: rsp_valid first high Tp+Tw+Ts+1 cycles after the accept edge. Out-of-range: 1 cycle after the accept edge.
- Invariants:
  - Precharge (PRE_*) is never high in the same cycle as any WWL/RWL/RWLB.
  - At most one WWL bit is high.
  - WE is high only in W_WL.
- Duration counters load on phase entry, count down, and never wrap.

Test Plan:
- Reset: hold reset_n=0 during M_SA -> next edge all wordlines 0, busy=0, rsp_valid=0; after release cmd_ready=1.
- WRITE row 3, data 16'hA5C3, t_pre=2, t_wl=3:
  - PRE_SRAM high for 2 cycles, then WWL=16'h0008, WE=1, SRAM_Din=A5C3 for 3 cycles.
  - cmd_ready returns 6 cycles after accept; no rsp_valid.
- READ row 15, t=1/1/1, SA_out=16'h0F0F -> rsp_valid at accept+4, rsp_data=0F0F, rsp_err=0. Hold rsp_ready=0 for 5 cycles -> data held, cmd_ready=0 throughout.
- MAC vec_p=16'h00FF, vec_n=16'h0F0F, t_sa=0, IMC_out=16'h1234:
  - RWL=00F0, RWLB=0F00; SAEN high exactly 1 cycle.
  - rsp_data=1234.
  - No cycle has a PRE_* signal high together with RWL/RWLB.
- READ row 16 (MEM_ROW=16) -> no control toggles, rsp_valid at accept+1 with rsp_err=1, rsp_data=0.
- Back-to-back: NOP, then WRITE, then MAC with rsp_ready tied 1 -> NOP gives no response, WRITE gives none, MAC gives exactly one response; busy low only between commands.
